// File: rtl/demux_pkg.sv
// Shared encodings for the round-robin / fixed-channel demux.
package demux_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;
  localparam int   NCH        = 4;

endpackage

// File: rtl/demux_rr_sched_rr_pick4.sv
// Four-way round-robin picker: first requester strictly after ptr in wrap
// order, falling back to ptr itself when it is the only requester.
module rr_pick4 (
  input  logic [1:0] ptr,
  input  logic [3:0] req,
  output logic [1:0] grant,
  output logic       any
);

  logic [1:0] w_idx;

  // Scan from the farthest candidate to the nearest so the nearest wins.
  always_comb begin
    grant = ptr;
    any   = |req;
    w_idx = 2'b00;
    for (int i = 4; i >= 1; i--) begin
      w_idx = ptr + 2'(i);
      if (req[w_idx]) grant = w_idx;
    end
  end

endmodule

// File: rtl/demux_rr_sched.sv
// Single-entry buffered 1-to-4 demux; each accepted word is routed either
// round-robin across enabled channels or to a fixed channel.
module demux_rr_sched
  import demux_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [1:0]    fixed_sel,
  input  logic [3:0]    ch_en,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [3:0]    out_ready,
  output logic [1:0]    cur_ch,
  output logic [CW-1:0] word_cnt
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_data;
  logic [1:0]    r_cur_ch;
  logic [1:0]    r_rr_ptr;
  logic [CW-1:0] r_word_cnt;

  logic [1:0]    w_rr_grant;
  logic          w_rr_any;
  logic [1:0]    w_target;
  logic          w_target_ok;
  logic          w_deliver;
  logic          w_in_ready;
  logic          w_accept;

  rr_pick4 u_pick (
    .ptr   (r_rr_ptr),
    .req   (ch_en),
    .grant (w_rr_grant),
    .any   (w_rr_any)
  );

  // Target for a word accepted this cycle; control inputs only matter here.
  always_comb begin
    w_target    = w_rr_grant;
    w_target_ok = w_rr_any;
    if (mode == MODE_FIXED) begin
      w_target    = fixed_sel;
      w_target_ok = ch_en[fixed_sel];
    end
  end

  // Only the held word's own channel can drain it; other readies are ignored.
  assign w_deliver  = (r_state == ST_FULL) && out_ready[r_cur_ch];
  // Refill in the same cycle as a drain keeps one word per cycle throughput.
  assign w_in_ready = !rst && w_target_ok && ((r_state == ST_EMPTY) || w_deliver);
  assign w_accept   = in_valid && w_in_ready;

  // Buffer occupancy next state.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)       w_state_nxt = ST_FULL;
    else if (w_deliver) w_state_nxt = ST_EMPTY;
  end

  // Occupancy register; reset discards any held word.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Held word, its target, round-robin pointer and delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_cur_ch   <= 2'd0;
      r_rr_ptr   <= 2'd3;
      r_word_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_data   <= in_data;
        r_cur_ch <= w_target;
        r_rr_ptr <= w_target;
      end
      if (w_deliver) r_word_cnt <= r_word_cnt + CW'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == ST_FULL) ? (4'b0001 << r_cur_ch) : 4'b0000;
  assign out_data  = r_data;
  assign cur_ch    = r_cur_ch;
  assign word_cnt  = r_word_cnt;

endmodule

// File: doc/demux_rr_sched.md
DEMUX_RR_SCHED -- requirements
Module: demux_rr_sched

Interface
REQ-001 SHALL have parameter DW, default 8: data word width in bits.
REQ-002 SHALL have parameter CW, default 16: width of the routed-word counter.
REQ-003 SHALL use a single clock; reset is synchronous and active-high.
REQ-004 clk  input  1  the only clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = round-robin, 1 = fixed channel.
REQ-007 fixed_sel  input  2  target channel when mode=1.
REQ-008 ch_en  input  4  per-channel enable; a disabled channel is never chosen as a new target.
REQ-009 in_valid  input  1  upstream word valid.
REQ-010 in_data  input  DW  upstream word.
REQ-011 in_ready  output  1  block accepts a word this cycle.
REQ-012 out_valid  output  4  one-hot; bit k means the held word is offered to channel k.
REQ-013 out_data  output  DW  held word, shared by all channels.
REQ-014 out_ready  input  4  per-channel downstream ready.
REQ-015 cur_ch  output  2  target channel of the held word (last target when empty).
REQ-016 word_cnt  output  CW  count of words delivered downstream.

Function
REQ-017 SHALL hold one word in a single-entry buffer with states EMPTY and FULL.
REQ-018 Accept: in_valid & in_ready.
REQ-019 Deliver: out_valid[cur_ch] & out_ready[cur_ch].
REQ-020 SHALL drive in_ready = target_ok & (EMPTY | deliver), combinationally, giving full throughput of one word per cycle.
REQ-021 target_ok SHALL be 0 when no eligible channel exists: ch_en=4'b0000 in mode 0, or ch_en[fixed_sel]=0 in mode 1.
REQ-022 In mode 0, the new target SHALL be the first enabled channel strictly after rr_ptr in wrap order ptr+1, ptr+2, ptr+3, ptr; if only rr_ptr itself is enabled, it is chosen.
REQ-023 In mode 1, the new target SHALL be fixed_sel.
REQ-024 mode, fixed_sel and ch_en SHALL be sampled only at accept; the held word keeps its target even if ch_en[cur_ch] drops or the mode changes afterwards.
REQ-025 On accept: out_data <= in_data, cur_ch <= target, rr_ptr <= target, state FULL.
REQ-026 rr_ptr SHALL also update on accepts made in mode 1.
REQ-027 out_valid SHALL be one-hot at cur_ch when FULL and all zeros when EMPTY; latency from accept to out_valid is 1 cycle.
REQ-028 Deliver without accept SHALL transition FULL to EMPTY; deliver with accept in the same cycle SHALL stay FULL and load the new word.
REQ-029 out_data SHALL stay stable while FULL and not delivered.
REQ-030 word_cnt SHALL increment by 1 on each deliver and wrap from 2^CW-1 to 0.
REQ-031 out_ready on non-target channels SHALL be ignored.

Reset
REQ-032 On rst: state EMPTY, out_valid=0, out_data=0, cur_ch=0, rr_ptr=3 (first round-robin grant is channel 0), word_cnt=0.
REQ-033 rst SHALL take priority over accept and deliver in the same cycle; a held word is discarded and not counted.
REQ-034 in_ready SHALL be 0 during any cycle in which rst is high.

Structure
REQ-035 demux_pkg SHALL hold the state encodings ST_EMPTY/ST_FULL, MODE_RR=0, MODE_FIXED=1, and NCH=4.
REQ-036 Round-robin selection SHALL live in combinational sub-module rr_pick4 (inputs ptr[1:0], req[3:0]; outputs grant[1:0], any).

Verification
REQ-037 Reset release, mode=0, ch_en=1111, out_ready=1111, words A,B,C,D,E back-to-back -> delivered to channels 0,1,2,3,0 in consecutive cycles; word_cnt=5; in_ready stays 1.
REQ-038 mode=0, ch_en=0101, 4 words -> channels 0,2,0,2; out_valid[1] and out_valid[3] never set.
REQ-039 mode=1, fixed_sel=2, out_ready[2]=0 for 3 cycles, then 1 -> out_valid=0100 with out_data stable for all 3 cycles, in_ready=0, then delivery; ch_en[2] cleared while held -> word still delivered to channel 2.
REQ-040 ch_en=0000 with in_valid=1 -> in_ready=0 and no accept; ch_en then set to 1000 -> next word goes to channel 3.
REQ-041 rst asserted while FULL with out_ready high -> out_valid=0000, word_cnt=0, cur_ch=0 next cycle; first word after reset goes to channel 0.
REQ-042 CW=4 with 17 deliveries -> word_cnt reads 1.
